// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS main control FSM and ALU decoder
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pcen,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               zeroext,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic               instr_done,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [STATE_W-1:0] {
        FETCH   = STATE_W'(0),
        DECODE  = STATE_W'(1),
        MEMADR  = STATE_W'(2),
        MEMRD   = STATE_W'(3),
        MEMWB   = STATE_W'(4),
        MEMWR   = STATE_W'(5),
        RTYPEEX = STATE_W'(6),
        ALUWB   = STATE_W'(7),
        BEQ     = STATE_W'(8),
        IMMEX   = STATE_W'(9),
        IMMWB   = STATE_W'(10),
        JUMP    = STATE_W'(11),
        BNE     = STATE_W'(12),
        ILLEGAL = STATE_W'(15)
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q, state_d;
    logic   pcwrite, branch, branchne;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branchne   = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        zeroext    = 1'b0;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        // Reset forces every enable and select low, not just the state register.
        if (!reset) begin
            alucontrol = 3'b000;
        end else begin
            unique case (state_q)
                FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = DECODE;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    case (op)
                        OP_LW, OP_SW:                      state_d = MEMADR;
                        OP_R:                              state_d = RTYPEEX;
                        OP_BEQ:                            state_d = BEQ;
                        OP_BNE:                            state_d = BNE;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = IMMEX;
                        OP_J:                              state_d = JUMP;
                        default:                           state_d = ILLEGAL;
                    endcase
                end
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    state_d = (op == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    iord    = 1'b1;
                    state_d = MEMWB;
                end
                MEMWB: begin
                    memtoreg   = 1'b1;
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWR: begin
                    iord       = 1'b1;
                    memwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    state_d = ALUWB;
                    case (funct)
                        6'b100000: alucontrol = ALU_ADD;
                        6'b100010: alucontrol = ALU_SUB;
                        6'b100100: alucontrol = ALU_AND;
                        6'b100101: alucontrol = ALU_OR;
                        6'b101010: alucontrol = ALU_SLT;
                        default:   state_d    = ILLEGAL;
                    endcase
                end
                ALUWB: begin
                    regdst     = 1'b1;
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                BEQ, BNE: begin
                    alusrca    = 1'b1;
                    alucontrol = ALU_SUB;
                    pcsrc      = 2'b01;
                    branch     = (state_q == BEQ);
                    branchne   = (state_q == BNE);
                    instr_done = 1'b1;
                end
                IMMEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    state_d = IMMWB;
                    case (op)
                        OP_ANDI: begin alucontrol = ALU_AND; zeroext = 1'b1; end
                        OP_ORI:  begin alucontrol = ALU_OR;  zeroext = 1'b1; end
                        OP_SLTI: alucontrol = ALU_SLT;
                        default: alucontrol = ALU_ADD;
                    endcase
                end
                IMMWB: begin
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                JUMP: begin
                    pcsrc      = 2'b10;
                    pcwrite    = 1'b1;
                    instr_done = 1'b1;
                end
                ILLEGAL: begin
                    illegal = 1'b1;
                    state_d = ILLEGAL;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign pcen    = pcwrite | (branch & zero) | (branchne & ~zero);
    assign state_o = state_q;

endmodule
